// File: rtl/alu_operand_stage.sv
// Operand-preparation stage feeding the 16-bit ALU: register file, writeback mux, A/B operand registers, B shifter.
// Optional same-cycle write-to-read forwarding is enabled by defining ALU_OPSTAGE_BYPASS_EN.
module alu_operand_stage #(
    parameter int unsigned DW   = 16,
    parameter int unsigned NREG = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    write,
    input  logic [$clog2(NREG)-1:0] writenum,
    input  logic [1:0]              vsel,
    input  logic [DW-1:0]           c_in,
    input  logic [DW-1:0]           mdata,
    input  logic [DW-1:0]           sximm8,
    input  logic [7:0]              pc,
    input  logic [$clog2(NREG)-1:0] readnum,
    input  logic                    loada,
    input  logic                    loadb,
    input  logic [1:0]              shift,
    input  logic                    asel,
    input  logic                    bsel,
    input  logic [DW-1:0]           sximm5,
    output logic [DW-1:0]           Ain,
    output logic [DW-1:0]           Bin,
    output logic [DW-1:0]           rd_data
);

    logic [DW-1:0] regs [NREG];
    logic [DW-1:0] a_q;
    logic [DW-1:0] b_q;
    logic [DW-1:0] wb_data;
    logic [DW-1:0] b_shift;

    // Writeback source select; pc is zero-extended to the datapath width.
    always_comb begin
        wb_data = c_in;
        case (vsel)
            2'b00:   wb_data = c_in;
            2'b01:   wb_data = DW'(pc);
            2'b10:   wb_data = sximm8;
            default: wb_data = mdata;
        endcase
    end

`ifdef ALU_OPSTAGE_BYPASS_EN
    // Forward the in-flight write so a same-cycle load sees the new value.
    always_comb begin
        rd_data = regs[readnum];
        if (write && (writenum == readnum)) begin
            rd_data = wb_data;
        end
    end
`else
    always_comb begin
        rd_data = regs[readnum];
    end
`endif

    // Register file and operand registers; reset wins over every load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (write) begin
                regs[writenum] <= wb_data;
            end
            if (loada) begin
                a_q <= rd_data;
            end
            if (loadb) begin
                b_q <= rd_data;
            end
        end
    end

    always_comb begin
        b_shift = b_q;
        case (shift)
            2'b00:   b_shift = b_q;
            2'b01:   b_shift = {b_q[DW-2:0], 1'b0};
            2'b10:   b_shift = {1'b0, b_q[DW-1:1]};
            default: b_shift = {b_q[DW-1], b_q[DW-1:1]};
        endcase
    end

    always_comb begin
        Ain = asel ? '0 : a_q;
        Bin = bsel ? sximm5 : b_shift;
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage: directed tables, corner sequences, randomized run against a reference model.
module tb_alu_operand_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        write;
    logic [2:0]  writenum;
    logic [1:0]  vsel;
    logic [15:0] c_in;
    logic [15:0] mdata;
    logic [15:0] sximm8;
    logic [7:0]  pc;
    logic [2:0]  readnum;
    logic        loada;
    logic        loadb;
    logic [1:0]  shift;
    logic        asel;
    logic        bsel;
    logic [15:0] sximm5;
    logic [15:0] Ain;
    logic [15:0] Bin;
    logic [15:0] rd_data;

    int n_checks = 0;
    int n_errors = 0;

    alu_operand_stage #(.DW(16), .NREG(8)) dut (
        .clk(clk), .rst_n(rst_n), .write(write), .writenum(writenum), .vsel(vsel),
        .c_in(c_in), .mdata(mdata), .sximm8(sximm8), .pc(pc), .readnum(readnum),
        .loada(loada), .loadb(loadb), .shift(shift), .asel(asel), .bsel(bsel),
        .sximm5(sximm5), .Ain(Ain), .Bin(Bin), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [1:0]  sel;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    vec_t wb_tab [4];
    vec_t sh_tab [4];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rst_n = 1'b1; write = 1'b0; writenum = 3'd0; vsel = 2'b00;
        c_in = 16'h0; mdata = 16'h0; sximm8 = 16'h0; pc = 8'h0;
        readnum = 3'd0; loada = 1'b0; loadb = 1'b0; shift = 2'b00;
        asel = 1'b0; bsel = 1'b0; sximm5 = 16'h0;
    endtask

    task automatic wr_reg(input logic [2:0] idx, input logic [15:0] val);
        write = 1'b1; writenum = idx; vsel = 2'b00; c_in = val;
        cyc();
        write = 1'b0;
    endtask

    // Reference model state.
    logic [15:0] m_regs [8];
    logic [15:0] m_a;
    logic [15:0] m_b;

    function automatic logic [15:0] m_shift(input logic [15:0] b, input logic [1:0] s);
        int unsigned v = int'(b);
        case (s)
            2'd0:    return b;
            2'd1:    return 16'((v * 2) % 65536);
            2'd2:    return 16'(v / 2);
            default: return 16'((v / 2) + ((v >= 32768) ? 32768 : 0));
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] exp_rd, wb;

        wb_tab[0] = '{"wb_c_in",   2'd0, 16'hABCD, 16'hABCD};
        wb_tab[1] = '{"wb_pc",     2'd1, 16'h005A, 16'h005A};
        wb_tab[2] = '{"wb_sximm8", 2'd2, 16'hFF80, 16'hFF80};
        wb_tab[3] = '{"wb_mdata",  2'd3, 16'h0F0F, 16'h0F0F};
        sh_tab[0] = '{"sh_none",   2'd0, 16'h8001, 16'h8001};
        sh_tab[1] = '{"sh_lsl1",   2'd1, 16'h8001, 16'h0002};
        sh_tab[2] = '{"sh_lsr1",   2'd2, 16'h8001, 16'h4000};
        sh_tab[3] = '{"sh_asr1",   2'd3, 16'h8001, 16'hC000};

        idle();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;

        // Reset clears registers and operands, even with loads pending.
        wr_reg(3'd3, 16'h1234);
        wr_reg(3'd7, 16'h00FF);
        readnum = 3'd7; loada = 1'b1; loadb = 1'b1;
        cyc();
        loada = 1'b0; loadb = 1'b0;
        #1;
        check("preload_ain", Ain, 16'h00FF);
        rst_n = 1'b0; write = 1'b1; writenum = 3'd3; c_in = 16'h5555; loada = 1'b1; loadb = 1'b1;
        cyc();
        idle();
        #1;
        check("reset_ain", Ain, 16'h0000);
        check("reset_bin", Bin, 16'h0000);
        for (int i = 0; i < 8; i++) begin
            readnum = 3'(i);
            #1;
            check($sformatf("reset_r%0d", i), rd_data, 16'h0000);
        end

        // Writeback mux, one source per entry; the other sources carry noise.
        foreach (wb_tab[i]) begin
            write = 1'b1; writenum = 3'd1; vsel = wb_tab[i].sel;
            c_in = 16'h1357; pc = 8'hC3; sximm8 = 16'h2468; mdata = 16'h9BDF;
            case (wb_tab[i].sel)
                2'd0:    c_in = wb_tab[i].data;
                2'd1:    pc = wb_tab[i].data[7:0];
                2'd2:    sximm8 = wb_tab[i].data;
                default: mdata = wb_tab[i].data;
            endcase
            cyc();
            write = 1'b0; readnum = 3'd1;
            #1;
            check(wb_tab[i].name, rd_data, wb_tab[i].exp);
        end
        idle();

        // Shifter on B.
        wr_reg(3'd4, 16'h8001);
        readnum = 3'd4; loadb = 1'b1;
        cyc();
        loadb = 1'b0;
        foreach (sh_tab[i]) begin
            shift = sh_tab[i].sel; bsel = 1'b0;
            #1;
            check(sh_tab[i].name, Bin, sh_tab[i].exp);
        end

        // Selects.
        wr_reg(3'd6, 16'h0007);
        readnum = 3'd6; loada = 1'b1;
        cyc();
        loada = 1'b0; asel = 1'b0;
        #1;
        check("asel0_ain", Ain, 16'h0007);
        asel = 1'b1;
        #1;
        check("asel1_ain", Ain, 16'h0000);
        asel = 1'b0; bsel = 1'b1; sximm5 = 16'hFFF0;
        for (int s = 0; s < 4; s++) begin
            shift = 2'(s);
            #1;
            check($sformatf("bsel1_sh%0d", s), Bin, 16'hFFF0);
        end
        idle();

        // Same-cycle write and load of the same register.
        wr_reg(3'd2, 16'h1111);
        write = 1'b1; writenum = 3'd2; vsel = 2'b00; c_in = 16'h2222;
        readnum = 3'd2; loada = 1'b1;
        cyc();
        write = 1'b0; loada = 1'b0;
        #1;
`ifdef ALU_OPSTAGE_BYPASS_EN
        check("bypass_a", Ain, 16'h2222);
`else
        check("bypass_a", Ain, 16'h1111);
`endif
        check("bypass_r2", rd_data, 16'h2222);

        // Both loads together; no write with write=0.
        wr_reg(3'd5, 16'h00AA);
        readnum = 3'd5; loada = 1'b1; loadb = 1'b1; writenum = 3'd5; c_in = 16'hDEAD;
        cyc();
        loada = 1'b0; loadb = 1'b0; shift = 2'b00; bsel = 1'b0; asel = 1'b0;
        #1;
        check("indep_a", Ain, 16'h00AA);
        check("indep_b", Bin, 16'h00AA);
        check("indep_r5", rd_data, 16'h00AA);

        // Randomized run against the reference model.
        idle();
        rst_n = 1'b0;
        cyc();
        foreach (m_regs[i]) m_regs[i] = 16'h0;
        m_a = 16'h0;
        m_b = 16'h0;
        for (int it = 0; it < 600; it++) begin
            rst_n    = ($urandom_range(31) != 0);
            write    = 1'($urandom);
            writenum = 3'($urandom);
            vsel     = 2'($urandom);
            c_in     = 16'($urandom);
            mdata    = 16'($urandom);
            sximm8   = 16'($urandom);
            pc       = 8'($urandom);
            readnum  = ($urandom_range(3) == 0) ? writenum : 3'($urandom);
            loada    = 1'($urandom);
            loadb    = 1'($urandom);
            shift    = 2'($urandom);
            asel     = 1'($urandom);
            bsel     = 1'($urandom);
            sximm5   = 16'($urandom);
            #1;
            wb = (vsel == 2'd0) ? c_in : (vsel == 2'd1) ? {8'h00, pc} :
                 (vsel == 2'd2) ? sximm8 : mdata;
            exp_rd = m_regs[readnum];
`ifdef ALU_OPSTAGE_BYPASS_EN
            if (write && writenum == readnum) exp_rd = wb;
`endif
            check("rand_rd", rd_data, exp_rd);
            check("rand_ain", Ain, asel ? 16'h0 : m_a);
            check("rand_bin", Bin, bsel ? sximm5 : m_shift(m_b, shift));
            if (!rst_n) begin
                foreach (m_regs[i]) m_regs[i] = 16'h0;
                m_a = 16'h0;
                m_b = 16'h0;
            end else begin
                if (write) m_regs[writenum] = wb;
                if (loada) m_a = exp_rd;
                if (loadb) m_b = exp_rd;
            end
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
# alu_operand_stage

Operand-preparation stage directly upstream of the 16-bit ALU in the Simple RISC Machine datapath. Holds the eight-entry general register file, the writeback-source multiplexer, the A and B operand registers, the B-path shifter and the A/B source selects. Drives the ALU's `Ain`/`Bin` inputs. All sequencing strobes come from the instruction controller FSM; this block contains no decode logic.

## Interface
Parameters:
- `DW`, 16: datapath width; ALU operands and register width.
- `NREG`, 8: number of general registers; register index width is 3.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1: rising-edge clock.
- `rst_n`  in  1: synchronous active-low reset.
- `write`  in  1: register-file write enable.
- `writenum`  in  3: destination register index.
- `vsel`  in  2: writeback source. 00 = `c_in`, 01 = `{8'b0, pc}`, 10 = `sximm8`, 11 = `mdata`.
- `c_in`  in  16: registered ALU result from the downstream C register.
- `mdata`  in  16: memory read data.
- `sximm8`  in  16: sign-extended 8-bit immediate.
- `pc`  in  8: program counter.
- `readnum`  in  3: register-file read index.
- `loada`  in  1: capture the read data into A.
- `loadb`  in  1: capture the read data into B.
- `shift`  in  2: B-path shift. 00 none, 01 LSL1, 10 LSR1, 11 ASR1.
- `asel`  in  1: 1 = `Ain` forced to 0; 0 = A.
- `bsel`  in  1: 1 = `Bin` = `sximm5`; 0 = shifted B.
- `sximm5`  in  16: sign-extended 5-bit immediate.
- `Ain`  out  16: ALU A operand.
- `Bin`  out  16: ALU B operand.
- `rd_data`  out  16: combinational register-file read of `readnum`, for the controller and debug.

## Operation
- **Reset** (`rst_n` = 0 at a rising edge): R0–R7, A and B all clear to 0. As a result, `Ain` = 0, `Bin` = 0 (when `bsel` = 0) and `rd_data` = 0. Reset has priority over `write`, `loada` and `loadb` in the same cycle.
- **Writeback**: when `write` = 1, R[`writenum`] takes `wb_data` at the rising edge. `wb_data` is selected by `vsel`. `pc` is zero-extended.
- **Read**: `rd_data` = R[`readnum`] combinationally, subject to the bypass rule under Configuration.
- **Operand registers**:
  - `loada` = 1: A takes `rd_data` at the edge.
  - `loadb` = 1: B takes `rd_data` at the edge.
  - Both may be asserted in the same cycle; both then capture the same value.
  - A deasserted load holds the register.
- **Shifter**, applied to B only, with width preserved:
  - LSL1 = `{B[14:0], 0}`
  - LSR1 = `{0, B[15:1]}`
  - ASR1 = `{B[15], B[15:1]}`
- **Output muxes**: `Ain` = `asel` ? 0 : A. `Bin` = `bsel` ? `sximm5` : shift(B). Both are purely combinational from registered state and inputs.
- No arithmetic is performed here. All values are passed bit-exact to the ALU.

## Timing
- **Write to read**: a register written at edge N is visible on `rd_data` after edge N.
- **Load to operand**: after `loada`/`loadb` at edge N, `Ain`/`Bin` reflect the new value in cycle N+1. The ALU result is available the same cycle; the downstream C register captures it at edge N+1.
- **Typical sequence**:
  - Cycle 0: `readnum` = Rn, `loada`.
  - Cycle 1: `readnum` = Rm, `loadb`, with `shift` and `bsel` set.
  - Cycle 2: ALU computes; the controller pulses the C load.
  - Cycle 3: `vsel` = 00, `write`.
- **Simultaneous write and load**, with `writenum` = `readnum` in the same cycle: behaviour is set by the macro under Configuration. In either case the register file itself stores `wb_data`.
- **Reset mid-sequence**: the entire state clears on that edge. The controller must restart the sequence; no partial state survives.
- `shift`, `asel` and `bsel` changes take effect combinationally in the same cycle. There is no hidden state.

## Configuration
- `ALU_OPSTAGE_BYPASS_EN`
  - Defined: `rd_data` = `wb_data` whenever `write` = 1 and `writenum` = `readnum`. A same-cycle `loada`/`loadb` therefore captures the value being written, which enables back-to-back dependent instructions.
  - Undefined: `rd_data` always shows the stored R[`readnum`]. A same-cycle load captures the old value, and the controller must insert a cycle between write and read.

## Test plan
- **Reset**: preload R3 = 0x1234 and A = B = 0x00FF, then hold `rst_n` = 0 for one edge. Required: R0–R7 = 0, A = B = 0, and `Ain` = `Bin` = 0 with `asel` = `bsel` = 0.
- **Writeback mux**: `write` R1 with each `vsel` source: `c_in` = 0xABCD, `pc` = 0x5A, `sximm8` = 0xFF80, `mdata` = 0x0F0F. Required: R1 reads 0xABCD, 0x005A, 0xFF80 and 0x0F0F respectively.
- **Shifter**: B = 0x8001 with `shift` = 00, 01, 10, 11. Required: `Bin` = 0x8001, 0x0002, 0x4000, 0xC000.
- **Selects**:
  - A = 0x0007, `asel` = 1: `Ain` = 0x0000.
  - `bsel` = 1, `sximm5` = 0xFFF0: `Bin` = 0xFFF0 regardless of B and `shift`.
- **Bypass**: R2 = 0x1111, then in one cycle `write` R2 = 0x2222 with `readnum` = 2 and `loada`. Required: A = 0x2222 with `ALU_OPSTAGE_BYPASS_EN` defined, A = 0x1111 without it. R2 = 0x2222 in both builds.
- **Independence**: `loada` and `loadb` in the same cycle with R5 = 0x00AA. Required: A = B = 0x00AA, and R5 is unchanged with `write` = 0.
